// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC launch controller: state codes, error codes, width helper.
package tdc_pkg;

  localparam int TAPS_DEF = 32;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] OUT    = 2'd2;

  typedef enum logic [1:0] {
    ERR_OK     = 2'b00,
    ERR_UNDER  = 2'b01,
    ERR_OVER   = 2'b10,
    ERR_BUBBLE = 2'b11
  } err_e;

  function automatic int fine_w(input int taps);
    return $clog2(taps) + 1;
  endfunction

endpackage

// File: rtl/tdc_thermo_encoder.sv
// Combinational thermometer-to-fine-count encoder with error classification.
// TDC_BUBBLE_FIX_EN selects popcount instead of leading-ones counting.
module tdc_thermo_encoder
  import tdc_pkg::*;
#(
  parameter  int TAPS   = TAPS_DEF,
  localparam int FINE_W = fine_w(TAPS)
) (
  input  logic [TAPS-1:0]   thermo_i,
  output logic [FINE_W-1:0] fine_o,
  output err_e              err_o
);

  logic [FINE_W-1:0] cnt;
  logic              seen_zero;
  logic              bubble;

  always_comb begin
    cnt       = '0;
    seen_zero = 1'b0;
    bubble    = 1'b0;
    for (int unsigned i = 0; i < TAPS; i++) begin
      if (thermo_i[i]) begin
        if (seen_zero) bubble = 1'b1;
`ifdef TDC_BUBBLE_FIX_EN
        cnt = cnt + FINE_W'(1);
`else
        if (!seen_zero) cnt = cnt + FINE_W'(1);
`endif
      end else begin
        seen_zero = 1'b1;
      end
    end
  end

  always_comb begin
    fine_o = cnt;
    if (~|thermo_i)      err_o = ERR_UNDER;
    else if (&thermo_i)  err_o = ERR_OVER;
    else if (bubble)     err_o = ERR_BUBBLE;
    else                 err_o = ERR_OK;
  end

endmodule

// File: rtl/tdc_launch_ctrl.sv
// TDC measurement controller: launch pulse, capture, encoded result stream, drain gap.
// Encoder behaviour depends on TDC_BUBBLE_FIX_EN (see tdc_thermo_encoder).
module tdc_launch_ctrl
  import tdc_pkg::*;
#(
  parameter  int TAPS        = TAPS_DEF,
  parameter  int CAPTURE_LAT = 2,
  parameter  int GAP         = 4,
  parameter  int SEQ_W       = 8,
  localparam int FINE_W      = fine_w(TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  output logic              busy,
  output logic              start_pulse,
  input  logic [TAPS-1:0]   thermo,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [FINE_W-1:0] m_fine,
  output logic [1:0]        m_err,
  output logic [SEQ_W-1:0]  m_seq
);

  localparam int LW = $clog2(CAPTURE_LAT + 2);
  localparam int DW = $clog2(GAP + 1);

  logic [1:0]        state_q, state_d;
  logic [LW-1:0]     lcnt_q, lcnt_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic              hs_done_q, hs_done_d;
  logic              start_q, start_d;
  logic              valid_q, valid_d;
  logic [FINE_W-1:0] fine_q, fine_d;
  logic [1:0]        err_q, err_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;

  logic [FINE_W-1:0] enc_fine;
  err_e              enc_err;
  logic              hs, launch_last, drain_last;

  tdc_thermo_encoder #(.TAPS(TAPS)) u_enc (
    .thermo_i (thermo),
    .fine_o   (enc_fine),
    .err_o    (enc_err)
  );

  assign hs          = valid_q & m_ready;
  // LAUNCH spends one cycle arming, then CAPTURE_LAT+1 cycles with the pulse high
  assign launch_last = (lcnt_q == LW'(CAPTURE_LAT + 1));
  assign drain_last  = (drain_q >= DW'(GAP - 1));

  always_comb begin
    state_d   = state_q;
    lcnt_d    = lcnt_q;
    drain_d   = drain_q;
    hs_done_d = hs_done_q;
    start_d   = start_q;
    valid_d   = valid_q;
    fine_d    = fine_q;
    err_d     = err_q;
    seq_d     = seq_q;
    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d = LAUNCH;
          lcnt_d  = '0;
        end
      end
      LAUNCH: begin
        if (launch_last) begin
          start_d   = 1'b0;
          valid_d   = 1'b1;
          fine_d    = enc_fine;
          err_d     = enc_err;
          drain_d   = '0;
          hs_done_d = 1'b0;
          state_d   = OUT;
        end else begin
          start_d = 1'b1;
          lcnt_d  = lcnt_q + LW'(1);
        end
      end
      OUT: begin
        if (hs) begin
          valid_d   = 1'b0;
          seq_d     = seq_q + SEQ_W'(1);
          hs_done_d = 1'b1;
        end
        if (drain_q != DW'(GAP)) drain_d = drain_q + DW'(1);
        if ((hs_done_q || hs) && drain_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      lcnt_q    <= '0;
      drain_q   <= '0;
      hs_done_q <= 1'b0;
      start_q   <= 1'b0;
      valid_q   <= 1'b0;
      fine_q    <= '0;
      err_q     <= '0;
      seq_q     <= '0;
    end else begin
      state_q   <= state_d;
      lcnt_q    <= lcnt_d;
      drain_q   <= drain_d;
      hs_done_q <= hs_done_d;
      start_q   <= start_d;
      valid_q   <= valid_d;
      fine_q    <= fine_d;
      err_q     <= err_d;
      seq_q     <= seq_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign start_pulse = start_q;
  assign m_valid     = valid_q;
  assign m_fine      = fine_q;
  assign m_err       = err_q;
  assign m_seq       = seq_q;

endmodule
